// File: rtl/s_mem_init_engine.sv
// Walks addresses 0..DEPTH-1 writing a mode-selected pattern, then pulses done.
// Define S_MEM_INIT_VERIFY_EN to add a read-back verify pass driving err/err_addr.
module s_mem_init_engine #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 256,
  parameter int GAP      = 0,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] fill_value,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] err_addr
);

  localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(DEPTH - 1);
  localparam logic [3:0]        GAP_LAST = 4'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [2:0] {
    ST_IDLE, ST_WRITE, ST_GAP, ST_DONE
`ifdef S_MEM_INIT_VERIFY_EN
    , ST_RD_ISSUE, ST_RD_WAIT
`endif
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] cnt_reg, cnt_next, cnt_plus;
  logic [3:0]        gap_reg, gap_next;
  logic [1:0]        mode_reg, mode_next;
  logic [DATA_W-1:0] fill_reg, fill_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic              wren_reg, wren_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic              next_write, last_write;

  function automatic logic [DATA_W-1:0] pattern(input logic [1:0]        m,
                                                input logic [DATA_W-1:0] f,
                                                input logic [ADDR_W-1:0] c);
    logic [ADDR_W-1:0] desc;
    desc = LAST - c;
    case (m)
      2'd0:    pattern = DATA_W'(c);
      2'd1:    pattern = f;
      2'd2:    pattern = DATA_W'(desc);
      default: pattern = DATA_W'(c) ^ f;
    endcase
  endfunction

`ifdef S_MEM_INIT_VERIFY_EN
  localparam logic [1:0] LAT_LAST = 2'(READ_LAT - 1);
  logic [1:0]        lat_reg, lat_next;
  logic              err_reg, err_next;
  logic [ADDR_W-1:0] err_addr_reg, err_addr_next;
`endif

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    cnt_plus   = cnt_reg + ADDR_W'(1);
    gap_next   = gap_reg;
    mode_next  = mode_reg;
    fill_next  = fill_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    wren_next  = 1'b0;
    busy_next  = busy_reg;
    done_next  = 1'b0;
    next_write = 1'b0;
    last_write = 1'b0;
`ifdef S_MEM_INIT_VERIFY_EN
    lat_next      = lat_reg;
    err_next      = err_reg;
    err_addr_next = err_addr_reg;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          mode_next  = mode;
          fill_next  = fill_value;
          cnt_next   = '0;
          state_next = ST_WRITE;
          wren_next  = 1'b1;
          addr_next  = '0;
          wdata_next = pattern(mode, fill_value, '0);
          busy_next  = 1'b1;
`ifdef S_MEM_INIT_VERIFY_EN
          err_next      = 1'b0;
          err_addr_next = '0;
`endif
        end
      end
      ST_WRITE: begin
        if (GAP > 0) begin
          state_next = ST_GAP;
          gap_next   = '0;
        end else if (cnt_reg == LAST) begin
          last_write = 1'b1;
        end else begin
          next_write = 1'b1;
        end
      end
      ST_GAP: begin
        // Address and data deliberately hold through the idle cycles.
        if (gap_reg == GAP_LAST) begin
          if (cnt_reg == LAST) last_write = 1'b1;
          else                 next_write = 1'b1;
        end else begin
          gap_next = gap_reg + 4'd1;
        end
      end
`ifdef S_MEM_INIT_VERIFY_EN
      ST_RD_ISSUE: begin
        state_next = ST_RD_WAIT;
        lat_next   = '0;
      end
      ST_RD_WAIT: begin
        if (lat_reg == LAT_LAST) begin
          // Only the first mismatch is recorded.
          if (!err_reg && (mem_q != pattern(mode_reg, fill_reg, cnt_reg))) begin
            err_next      = 1'b1;
            err_addr_next = cnt_reg;
          end
          if (cnt_reg == LAST) begin
            state_next = ST_DONE;
            done_next  = 1'b1;
          end else begin
            cnt_next   = cnt_plus;
            addr_next  = cnt_plus;
            state_next = ST_RD_ISSUE;
          end
        end else begin
          lat_next = lat_reg + 2'd1;
        end
      end
`endif
      ST_DONE: begin
        state_next = ST_IDLE;
        busy_next  = 1'b0;
        addr_next  = '0;
        wdata_next = '0;
      end
      default: state_next = ST_IDLE;
    endcase

    if (next_write) begin
      cnt_next   = cnt_plus;
      state_next = ST_WRITE;
      wren_next  = 1'b1;
      addr_next  = cnt_plus;
      wdata_next = pattern(mode_reg, fill_reg, cnt_plus);
    end
    if (last_write) begin
`ifdef S_MEM_INIT_VERIFY_EN
      state_next = ST_RD_ISSUE;
      cnt_next   = '0;
      addr_next  = '0;
`else
      state_next = ST_DONE;
      done_next  = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      gap_reg   <= '0;
      mode_reg  <= '0;
      fill_reg  <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      wren_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      gap_reg   <= gap_next;
      mode_reg  <= mode_next;
      fill_reg  <= fill_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      wren_reg  <= wren_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

`ifdef S_MEM_INIT_VERIFY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_reg      <= '0;
      err_reg      <= 1'b0;
      err_addr_reg <= '0;
    end else begin
      lat_reg      <= lat_next;
      err_reg      <= err_next;
      err_addr_reg <= err_addr_next;
    end
  end

  assign err      = err_reg;
  assign err_addr = err_addr_reg;
`else
  logic       unused_mem_q;
  logic [1:0] unused_lat;
  assign unused_mem_q = ^mem_q;
  assign unused_lat   = 2'(READ_LAT);
  assign err          = 1'b0;
  assign err_addr     = '0;
`endif

  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign mem_wren  = wren_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;

endmodule

// File: tb/tb_s_mem_init_engine.sv
// Scoreboard bench: two engine instances (256/no gap, 16/gap 2) with RAM models,
// driven by randomized passes and checked against expected write/done queues.
module tb_s_mem_init_engine;

`ifdef S_MEM_INIT_VERIFY_EN
  localparam int VER = 1;
`else
  localparam int VER = 0;
`endif

  typedef struct { int addr; int data; int cyc; } wr_t;
  typedef struct { int from; int cyc; int err; int eaddr; int mode; int fill; bit cor; } dn_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   fin [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int pat(input int m, input int f, input int d, input int i);
    case (m)
      0:       return i % 256;
      1:       return f % 256;
      2:       return (d - 1 - i) % 256;
      default: return (i ^ f) % 256;
    endcase
  endfunction

  task automatic chk(input int inst, input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL inst%0d %s: got %0d expected %0d at cycle %0d", inst, nm, act, exp, cyc);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int D     = (gi == 0) ? 256 : 16;
    localparam int G     = (gi == 0) ? 0 : 2;
    localparam int WDIST = (gi == 0) ? 100 : 9;
    localparam int RADDR = (gi == 0) ? 37 : 7;
    localparam int CADDR = (gi == 0) ? 'h42 : 5;

    logic       rst, start, wren, busy, done, err, corrupt;
    logic [1:0] mode;
    logic [7:0] fill, addr, wdata, q, eaddr;
    logic [7:0] mem [256];
    wr_t        wq [$];
    dn_t        dq [$];

    s_mem_init_engine #(
      .ADDR_W(8), .DATA_W(8), .DEPTH(D), .GAP(G), .READ_LAT(1)
    ) dut (
      .clk(clk), .reset(rst), .start(start), .mode(mode), .fill_value(fill),
      .mem_addr(addr), .mem_wdata(wdata), .mem_wren(wren), .mem_q(q),
      .busy(busy), .done(done), .err(err), .err_addr(eaddr)
    );

    // RAM model with one-cycle registered read; optionally corrupts one entry.
    always @(posedge clk) begin
      if (wren) mem[addr] <= (corrupt && addr == 8'(CADDR)) ? ~wdata : wdata;
      q <= mem[addr];
    end

    always @(negedge clk) begin
      wr_t w;
      dn_t d;
      int  exp_busy;
      int  bad;
      exp_busy = (dq.size() > 0 && cyc >= dq[0].from && cyc <= dq[0].cyc) ? 1 : 0;
      chk(gi, "busy", busy, exp_busy);
      if (wren) begin
        if (wq.size() == 0) begin
          checks++; errors++;
          $display("FAIL inst%0d unexpected_write: addr %0d data %0d at cycle %0d", gi, addr, wdata, cyc);
        end else begin
          w = wq.pop_front();
          chk(gi, "wr_addr", addr, w.addr);
          chk(gi, "wr_data", wdata, w.data);
          chk(gi, "wr_cycle", cyc, w.cyc);
        end
      end
      if (done) begin
        if (dq.size() == 0) begin
          checks++; errors++;
          $display("FAIL inst%0d unexpected_done at cycle %0d", gi, cyc);
        end else begin
          d = dq.pop_front();
          chk(gi, "done_cycle", cyc, d.cyc);
          chk(gi, "err", err, d.err);
          chk(gi, "err_addr", eaddr, d.eaddr);
          bad = 0;
          for (int i = 0; i < D; i++) begin
            int e;
            e = pat(d.mode, d.fill, D, i);
            if (d.cor && i == CADDR) e = (~e) & 255;
            if (int'(mem[i]) != e) bad++;
          end
          chk(gi, "mem_bad_entries", bad, 0);
          $display("inst%0d pass mode %0d fill 0x%02h done_cycle %0d err %0d err_addr 0x%02h",
                   gi, d.mode, d.fill, cyc, err, eaddr);
        end
      end
    end

    task automatic launch(input int m, input int f, input int e, input bit cor);
      int dcyc;
      dcyc = e + D * (1 + G) + VER * D * 2;
      for (int i = 0; i < D; i++) wq.push_back('{i, pat(m, f, D, i), e + i * (1 + G)});
      dq.push_back('{e, dcyc, (VER == 1 && cor) ? 1 : 0, (VER == 1 && cor) ? CADDR : 0, m, f, cor});
    endtask

    task automatic go(input int m, input int f, input bit cor);
      @(negedge clk);
      mode = 2'(m); fill = 8'(f); corrupt = cor; start = 1'b1;
      launch(m, f, cyc + 1, cor);
      @(negedge clk);
      start = 1'b0;
      mode  = 2'($urandom_range(0, 3));
      fill  = 8'($urandom_range(0, 255));
    endtask

    task automatic wait_idle();
      int k;
      k = 0;
      while (dq.size() != 0 && k < 3000) begin @(negedge clk); k++; end
      if (dq.size() != 0) begin
        checks++; errors++;
        $display("FAIL inst%0d done_timeout: got no done, required done by cycle %0d", gi, dq[0].cyc);
        dq.delete(); wq.delete();
      end
      @(negedge clk);
    endtask

    task automatic wait_write(input int a);
      int k;
      k = 0;
      while (!(wren && int'(addr) == a) && k < 3000) begin @(negedge clk); k++; end
      if (k >= 3000) begin
        checks++; errors++;
        $display("FAIL inst%0d write_timeout: got no write, required write to %0d", gi, a);
      end
    endtask

    initial begin
      int m1, f1, m2, f2, k;
      rst = 1'b1; start = 1'b0; mode = '0; fill = '0; corrupt = 1'b0;
      repeat (3) @(negedge clk);
      chk(gi, "reset_wren", wren, 0);
      chk(gi, "reset_addr", addr, 0);
      chk(gi, "reset_done", done, 0);
      rst = 1'b0;

      go(0, $urandom_range(0, 255), 1'b0); wait_idle();
      go(1, 'hA5, 1'b0);                   wait_idle();
      go(2, $urandom_range(0, 255), 1'b0); wait_idle();
      go(3, 'h0F, 1'b0);                   wait_idle();

      // Start pulse and mode/fill change mid-pass must be ignored.
      go(0, $urandom_range(0, 255), 1'b0);
      wait_write(WDIST);
      start = 1'b1; mode = 2'd1; fill = ~fill;
      @(negedge clk);
      start = 1'b0;
      wait_idle();

      // Reset in the middle of a write: outputs drop at once, no later writes.
      go(3, $urandom_range(1, 255), 1'b0);
      wait_write(RADDR);
      #2 rst = 1'b1;
      #1;
      chk(gi, "midrst_wren", wren, 0);
      chk(gi, "midrst_addr", addr, 0);
      chk(gi, "midrst_wdata", wdata, 0);
      chk(gi, "midrst_busy", busy, 0);
      chk(gi, "midrst_done", done, 0);
      wq.delete(); dq.delete();
      @(negedge clk);
      rst = 1'b0;
      repeat (8) @(negedge clk);
      go(0, $urandom_range(0, 255), 1'b0); wait_idle();

      // Corrupted memory entry: verify build must flag it.
      go($urandom_range(0, 3), $urandom_range(0, 255), 1'b1); wait_idle();
      go(0, $urandom_range(0, 255), 1'b0);                    wait_idle();

      // Start held high through done launches exactly one follow-on pass.
      @(negedge clk);
      m1 = $urandom_range(0, 3); f1 = $urandom_range(0, 255);
      mode = 2'(m1); fill = 8'(f1); corrupt = 1'b0; start = 1'b1;
      launch(m1, f1, cyc + 1, 1'b0);
      k = 0;
      while (!done && k < 3000) begin @(negedge clk); k++; end
      m2 = $urandom_range(0, 3); f2 = $urandom_range(0, 255);
      mode = 2'(m2); fill = 8'(f2);
      launch(m2, f2, cyc + 2, 1'b0);
      @(negedge clk);
      @(negedge clk);
      start = 1'b0;
      wait_idle();

      for (int p = 0; p < 2; p++) begin
        go($urandom_range(0, 3), $urandom_range(0, 255), 1'b0);
        wait_idle();
      end
      repeat (5) @(negedge clk);
      fin[gi] = 1'b1;
    end
  end

  initial begin
    int k;
    k = 0;
    while (!(fin[0] && fin[1]) && k < 60000) begin @(negedge clk); k++; end
    if (!(fin[0] && fin[1])) begin
      checks++; errors++;
      $display("FAIL bench_timeout: got unfinished instances, required both finished");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
